// File: rtl/rover_drive_pkg.sv
// Shared types and helpers for the rover drive command stage.
package rover_drive_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        BRAKE = 2'd1,
        DEAD  = 2'd2,
        FAULT = 2'd3
    } drive_state_t;

    localparam int SPEED_W = 3;
    localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;

    // One ramp step from cur toward tgt; never wraps past 0 or SPEED_MAX.
    function automatic logic [SPEED_W-1:0] step_toward(input logic [SPEED_W-1:0] cur,
                                                       input logic [SPEED_W-1:0] tgt);
        logic [SPEED_W-1:0] res;
        res = cur;
        if ((cur < tgt) && (cur != SPEED_MAX)) begin
            res = cur + 1'b1;
        end else if ((cur > tgt) && (cur != '0)) begin
            res = cur - 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/drive_channel.sv
// One motor channel: speed ramp, reversal sequencing (brake, dead time, flip),
// overcurrent synchronizer and stall counter. Fault entry/exit is commanded
// by the parent through i_force_fault / i_clear_fault.
module drive_channel
    import rover_drive_pkg::*;
#(
    parameter int RAMP_TICKS   = 10_000_000,
    parameter int DEAD_TICKS   = 5_000_000,
    parameter int STALL_CYCLES = 2_000_000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [SPEED_W-1:0] i_target,
    input  logic               i_dir_cmd,
    input  logic               i_ocp,
    input  logic               i_force_fault,
    input  logic               i_clear_fault,
    output logic [SPEED_W-1:0] o_speed,
    output logic               o_hb_dir,
    output logic               o_stall_hit
);
    localparam int RAMP_W  = $clog2(RAMP_TICKS + 1);
    localparam int DEAD_W  = $clog2(DEAD_TICKS + 1);
    localparam int STALL_W = $clog2(STALL_CYCLES + 1);
    localparam logic [RAMP_W-1:0]  RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);
    localparam logic [DEAD_W-1:0]  DEAD_LOAD = DEAD_W'(DEAD_TICKS);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_CYCLES);
    localparam logic [STALL_W-1:0] STALL_PRE = STALL_W'(STALL_CYCLES - 1);

    drive_state_t       r_state;
    drive_state_t       w_state_next;
    logic [SPEED_W-1:0] r_speed;
    logic [SPEED_W-1:0] w_speed_next;
    logic               r_hb_dir;
    logic               w_hb_dir_next;
    logic [DEAD_W-1:0]  r_dead_cnt;
    logic [DEAD_W-1:0]  w_dead_next;
    logic [RAMP_W-1:0]  r_ramp_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_ocp_meta;
    logic               r_ocp_sync;
    logic               w_tick;
    logic               w_dir_change;
    logic               w_dead_done;
    logic               w_ocp_active;

    assign w_tick       = (r_ramp_cnt == RAMP_LAST);
    assign w_dir_change = (i_dir_cmd != r_hb_dir);
    assign w_dead_done  = (r_dead_cnt <= DEAD_W'(1));
    // Overcurrent only counts while the motor is actually driven.
    assign w_ocp_active = r_ocp_sync && (r_speed != '0);
    assign o_stall_hit  = w_ocp_active && (r_stall_cnt == STALL_PRE);
    assign o_speed      = r_speed;
    assign o_hb_dir     = r_hb_dir;

    // Ramp tick counter, ocp synchronizer and saturating stall counter.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ramp_cnt  <= '0;
            r_ocp_meta  <= 1'b0;
            r_ocp_sync  <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_ramp_cnt <= w_tick ? '0 : r_ramp_cnt + 1'b1;
            r_ocp_meta <= i_ocp;
            r_ocp_sync <= r_ocp_meta;
            if (!w_ocp_active) begin
                r_stall_cnt <= '0;
            end else if (r_stall_cnt != STALL_MAX) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    // State register together with the registered speed/direction outputs.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= RUN;
            r_speed    <= '0;
            r_hb_dir   <= 1'b0;
            r_dead_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_speed    <= w_speed_next;
            r_hb_dir   <= w_hb_dir_next;
            r_dead_cnt <= w_dead_next;
        end
    end

    // Next-state logic; clear beats force so the exit cycle wins over the held fault.
    always_comb begin
        w_state_next = r_state;
        if (i_clear_fault) begin
            w_state_next = RUN;
        end else if (i_force_fault) begin
            w_state_next = FAULT;
        end else begin
            case (r_state)
                RUN:     if (w_dir_change) w_state_next = BRAKE;
                BRAKE: begin
                    if (!w_dir_change)         w_state_next = RUN;
                    else if (r_speed == '0)    w_state_next = DEAD;
                end
                DEAD:    if (w_dead_done) w_state_next = RUN;
                FAULT:   w_state_next = FAULT;
                default: w_state_next = RUN;
            endcase
        end
    end

    // Datapath for the next speed, applied direction and dead-time counter.
    always_comb begin
        w_speed_next  = r_speed;
        w_hb_dir_next = r_hb_dir;
        w_dead_next   = r_dead_cnt;
        if (i_clear_fault || i_force_fault) begin
            w_speed_next = '0;
        end else begin
            case (r_state)
                RUN: begin
                    if (!w_dir_change && w_tick) w_speed_next = step_toward(r_speed, i_target);
                end
                BRAKE: begin
                    if (w_dir_change && (r_speed == '0)) begin
                        w_dead_next = DEAD_LOAD;
                    end else if (w_dir_change && w_tick) begin
                        w_speed_next = r_speed - 1'b1;
                    end
                end
                DEAD: begin
                    // DEAD lasts DEAD_TICKS cycles; a request that went back to
                    // the applied direction simply leaves it unchanged.
                    if (w_dead_done) w_hb_dir_next = i_dir_cmd;
                    else             w_dead_next   = r_dead_cnt - 1'b1;
                end
                default: w_speed_next = '0;
            endcase
        end
    end

endmodule

// File: rtl/rover_drive_ctrl.sv
// Rover drive command stage: two ramped channels plus the shared stall fault.
// A stall on either channel stops both motors. Build option STALL_LATCH_EN
// makes the fault sticky until reset (no cooldown counter); without it the
// fault auto-clears after the cooldown once both targets are zero.
module rover_drive_ctrl
    import rover_drive_pkg::*;
#(
    parameter int RAMP_TICKS     = 10_000_000,
    parameter int DEAD_TICKS     = 5_000_000,
    parameter int STALL_CYCLES   = 2_000_000,
    parameter int COOLDOWN_TICKS = 100_000_000
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [SPEED_W-1:0] i_target_left,
    input  logic [SPEED_W-1:0] i_target_right,
    input  logic               i_dir_left,
    input  logic               i_dir_right,
    input  logic               i_ocp_left,
    input  logic               i_ocp_right,
    output logic [SPEED_W-1:0] o_speed_left,
    output logic [SPEED_W-1:0] o_speed_right,
    output logic               o_hb_dir_left,
    output logic               o_hb_dir_right,
    output logic               o_fault_left,
    output logic               o_fault_right,
    output logic               o_fault
);
    logic [SPEED_W-1:0] w_target [2];
    logic [SPEED_W-1:0] w_speed  [2];
    logic [1:0]         w_dir_cmd;
    logic [1:0]         w_ocp;
    logic [1:0]         w_hb_dir;
    logic [1:0]         w_stall_hit;
    logic               r_fault_left;
    logic               r_fault_right;
    logic               r_fault;
    logic               w_fault_left_next;
    logic               w_fault_right_next;
    logic               w_clear;

    assign w_target[0] = i_target_left;
    assign w_target[1] = i_target_right;
    assign w_dir_cmd   = {i_dir_right, i_dir_left};
    assign w_ocp       = {i_ocp_right, i_ocp_left};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            drive_channel #(
                .RAMP_TICKS   (RAMP_TICKS),
                .DEAD_TICKS   (DEAD_TICKS),
                .STALL_CYCLES (STALL_CYCLES)
            ) u_channel (
                .i_clock       (i_clock),
                .i_reset       (i_reset),
                .i_target      (w_target[gi]),
                .i_dir_cmd     (w_dir_cmd[gi]),
                .i_ocp         (w_ocp[gi]),
                .i_force_fault (r_fault),
                .i_clear_fault (w_clear),
                .o_speed       (w_speed[gi]),
                .o_hb_dir      (w_hb_dir[gi]),
                .o_stall_hit   (w_stall_hit[gi])
            );
        end
    endgenerate

`ifdef STALL_LATCH_EN
    assign w_clear = 1'b0;
`else
    localparam int COOL_W = $clog2(COOLDOWN_TICKS + 1);
    localparam logic [COOL_W-1:0] COOL_MAX = COOL_W'(COOLDOWN_TICKS);
    logic [COOL_W-1:0] r_cool_cnt;

    // Cooldown runs from fault entry and saturates; idle at zero otherwise.
    always_ff @(posedge i_clock) begin
        if (i_reset || !r_fault) begin
            r_cool_cnt <= '0;
        end else if (r_cool_cnt != COOL_MAX) begin
            r_cool_cnt <= r_cool_cnt + 1'b1;
        end
    end

    assign w_clear = r_fault && (r_cool_cnt >= COOL_MAX)
                     && (i_target_left == '0) && (i_target_right == '0);
`endif

    assign w_fault_left_next  = w_clear ? 1'b0 : (r_fault_left  | w_stall_hit[0]);
    assign w_fault_right_next = w_clear ? 1'b0 : (r_fault_right | w_stall_hit[1]);

    // Sticky per-channel stall flags and their registered OR.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_fault_left  <= 1'b0;
            r_fault_right <= 1'b0;
            r_fault       <= 1'b0;
        end else begin
            r_fault_left  <= w_fault_left_next;
            r_fault_right <= w_fault_right_next;
            r_fault       <= w_fault_left_next | w_fault_right_next;
        end
    end

    assign o_speed_left   = w_speed[0];
    assign o_speed_right  = w_speed[1];
    assign o_hb_dir_left  = w_hb_dir[0];
    assign o_hb_dir_right = w_hb_dir[1];
    assign o_fault_left   = r_fault_left;
    assign o_fault_right  = r_fault_right;
    assign o_fault        = r_fault;

endmodule

// File: tb/tb_rover_drive_ctrl.sv
// Scoreboard bench for rover_drive_ctrl: a behavioural model predicts the
// outputs after every clock edge; a monitor compares them one cycle at a time.
module tb_rover_drive_ctrl;
    localparam int RAMP  = 4;
    localparam int DEAD  = 3;
    localparam int STALL = 5;
    localparam int COOL  = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] tl, tr;
    logic       dl, dr, ocl, ocr;
    logic [2:0] spd_l, spd_r;
    logic       hb_l, hb_r, f_l, f_r, f_any;

    always #5 clk = ~clk;

    rover_drive_ctrl #(
        .RAMP_TICKS     (RAMP),
        .DEAD_TICKS     (DEAD),
        .STALL_CYCLES   (STALL),
        .COOLDOWN_TICKS (COOL)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_target_left  (tl),
        .i_target_right (tr),
        .i_dir_left     (dl),
        .i_dir_right    (dr),
        .i_ocp_left     (ocl),
        .i_ocp_right    (ocr),
        .o_speed_left   (spd_l),
        .o_speed_right  (spd_r),
        .o_hb_dir_left  (hb_l),
        .o_hb_dir_right (hb_r),
        .o_fault_left   (f_l),
        .o_fault_right  (f_r),
        .o_fault        (f_any)
    );

    int total = 0;
    int bad   = 0;
    logic [10:0] exp_q [$];

    // Behavioural model: speed, applied direction, "braking" flag, remaining
    // dead time, ocp delay line, stall run length, fault flags, cooldown age.
    int m_spd [2];
    int m_dir [2];
    int m_brk [2];
    int m_dead [2];
    int m_d1 [2];
    int m_d2 [2];
    int m_stall [2];
    int m_fl [2];
    int m_fault;
    int m_cool;
    int m_phase;

    task automatic model_step();
        int  tgt [2];
        int  dcmd [2];
        int  ocp [2];
        int  hit [2];
        bit  tick;
        bit  clr;
        tgt[0] = int'(tl); tgt[1] = int'(tr);
        dcmd[0] = int'(dl); dcmd[1] = int'(dr);
        ocp[0] = int'(ocl); ocp[1] = int'(ocr);
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                m_spd[c] = 0; m_dir[c] = 0; m_brk[c] = 0; m_dead[c] = 0;
                m_d1[c] = 0; m_d2[c] = 0; m_stall[c] = 0; m_fl[c] = 0;
            end
            m_fault = 0; m_cool = 0; m_phase = 0;
        end else begin
            tick = (m_phase == RAMP - 1);
            clr  = 1'b0;
`ifndef STALL_LATCH_EN
            clr = (m_fault != 0) && (m_cool >= COOL) && (tgt[0] == 0) && (tgt[1] == 0);
`endif
            m_cool = (m_fault != 0) ? ((m_cool < COOL) ? m_cool + 1 : m_cool) : 0;
            for (int c = 0; c < 2; c++) begin
                hit[c] = (m_d2[c] != 0 && m_spd[c] != 0 && m_stall[c] == STALL - 1) ? 1 : 0;
                if (m_d2[c] != 0 && m_spd[c] != 0)
                    m_stall[c] = (m_stall[c] < STALL) ? m_stall[c] + 1 : STALL;
                else
                    m_stall[c] = 0;
                m_d2[c] = m_d1[c];
                m_d1[c] = ocp[c];
                if (clr || m_fault != 0) begin
                    m_spd[c] = 0; m_brk[c] = 0; m_dead[c] = 0;
                end else if (m_dead[c] > 0) begin
                    if (m_dead[c] == 1) begin
                        m_dir[c]  = dcmd[c];
                        m_dead[c] = 0;
                    end else begin
                        m_dead[c] = m_dead[c] - 1;
                    end
                end else if (m_brk[c] != 0) begin
                    if (dcmd[c] == m_dir[c]) begin
                        m_brk[c] = 0;
                    end else if (m_spd[c] == 0) begin
                        m_brk[c]  = 0;
                        m_dead[c] = DEAD;
                    end else if (tick) begin
                        m_spd[c] = m_spd[c] - 1;
                    end
                end else begin
                    if (dcmd[c] != m_dir[c]) begin
                        m_brk[c] = 1;
                    end else if (tick) begin
                        if (tgt[c] > m_spd[c])      m_spd[c] = m_spd[c] + 1;
                        else if (tgt[c] < m_spd[c]) m_spd[c] = m_spd[c] - 1;
                    end
                end
            end
            for (int c = 0; c < 2; c++) m_fl[c] = clr ? 0 : (m_fl[c] | hit[c]);
            m_fault = m_fl[0] | m_fl[1];
            m_phase = (m_phase + 1) % RAMP;
        end
        exp_q.push_back({3'(m_spd[0]), 3'(m_spd[1]), m_dir[0][0], m_dir[1][0],
                         m_fl[0][0], m_fl[1][0], m_fault[0]});
    endtask

    // Predict the effect of the inputs currently applied, then advance a cycle.
    task automatic step(input int n);
        repeat (n) begin
            model_step();
            @(negedge clk);
        end
    endtask

    // Monitor: outputs are stable 1 time unit after the rising edge.
    initial begin
        forever begin : mon
            logic [10:0] e;
            logic [10:0] a;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {spd_l, spd_r, hb_l, hb_r, f_l, f_r, f_any};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs n=%0d got spdL=%0d spdR=%0d hbL=%b hbR=%b fL=%b fR=%b f=%b required spdL=%0d spdR=%0d hbL=%b hbR=%b fL=%b fR=%b f=%b",
                             total, a[10:8], a[7:5], a[4], a[3], a[2], a[1], a[0],
                             e[10:8], e[7:5], e[4], e[3], e[2], e[1], e[0]);
                end else begin
                    $display("n=%0d ok spdL=%0d spdR=%0d hbL=%b hbR=%b fL=%b fR=%b f=%b",
                             total, a[10:8], a[7:5], a[4], a[3], a[2], a[1], a[0]);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; tl = '0; tr = '0; dl = 1'b0; dr = 1'b0; ocl = 1'b0; ocr = 1'b0;
        @(negedge clk);
        step(3);
        rst = 1'b0;

        // Forward request at standstill, then ramp left 0 -> 7 and hold.
        dl = 1'b1; dr = 1'b1;
        step(12);
        tl = 3'd7;
        step(36);

        // Ramp down, retarget to 2 when passing 5.
        tl = 3'd0;
        for (int i = 0; i < 40 && m_spd[0] != 5; i++) step(1);
        tl = 3'd2;
        step(20);

        // Reversal at speed 3.
        tl = 3'd3;
        step(12);
        dl = 1'b0;
        step(40);

        // Right channel: short ocp pulses (no fault) then a held stall.
        tr = 3'd4;
        step(25);
        repeat (3) begin
            ocr = 1'b1; step(4);
            ocr = 1'b0; step(4);
        end
        ocr = 1'b1;
        step(12);
        ocr = 1'b0;

        // Fault held by non-zero targets, then released, then re-ramp.
        tl = 3'd4; tr = 3'd4;
        step(30);
        tl = 3'd0; tr = 3'd0;
        step(4);
        tl = 3'd3;
        step(20);

        // Reset during BRAKE.
        tl = 3'd5;
        step(25);
        dl = ~dl;
        step(3);
        rst = 1'b1; step(1); rst = 1'b0;
        step(4);

        // Reset during FAULT.
        tr = 3'd3; dr = 1'b0;
        step(20);
        ocr = 1'b1;
        step(12);
        rst = 1'b1; ocr = 1'b0; step(1); rst = 1'b0;

        // Overcurrent at speed 0 is ignored.
        tl = '0; tr = '0; ocl = 1'b1; ocr = 1'b1;
        step(20);
        ocl = 1'b0; ocr = 1'b0;

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 15) == 0) tl = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 15) == 0) tr = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 40) == 0) begin tl = '0; tr = '0; end
            if ($urandom_range(0, 60) == 0) dl = ~dl;
            if ($urandom_range(0, 60) == 0) dr = ~dr;
            if ($urandom_range(0, 20) == 0) ocl = ~ocl;
            if ($urandom_range(0, 20) == 0) ocr = ~ocr;
            rst = ($urandom_range(0, 499) == 0);
            step(1);
        end
        rst = 1'b0;
        step(3);

        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d required pending=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
